// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the 16K x 19-bit data memory. Handles
// single-word LOAD/STORE plus multi-cycle block FILL and forward COPY.
module load_store_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_data,
    input  logic [ADDR_W-1:0] req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, FILL, COPY_RD, COPY_WR, DONE
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   src_reg;
    logic [ADDR_W-1:0]   dst_reg;
    logic [ADDR_W-1:0]   remaining_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   hold_reg;
    logic [DATA_W-1:0]   resp_data_reg;
    logic                write_req;
    logic                accept;
    logic [ADDR_W-1:0]   ea;

    assign ea         = req_base + req_offset;
    assign req_ready  = (state_reg == IDLE) && reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_reg == DONE);
    assign resp_data  = resp_data_reg;
    assign busy       = (state_reg != IDLE);
    assign mem_write_en = write_req && reset;

    // The block loops check the remaining count on entry, so the final pass
    // through FILL / COPY_RD performs no memory access and only exits.
    always_comb begin
        state_next     = state_reg;
        mem_address    = '0;
        mem_write_data = '0;
        write_req      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_LOAD:  state_next = LOAD;
                        OP_STORE: state_next = STORE;
                        OP_COPY:  state_next = (req_len == '0) ? DONE : COPY_RD;
                        default:  state_next = (req_len == '0) ? DONE : FILL;
                    endcase
                end
            end
            LOAD: begin
                mem_address = src_reg;
                state_next  = DONE;
            end
            STORE: begin
                mem_address    = src_reg;
                mem_write_data = data_reg;
                write_req      = 1'b1;
                state_next     = DONE;
            end
            FILL: begin
                mem_address    = dst_reg;
                mem_write_data = data_reg;
                if (remaining_reg == '0) begin
                    state_next = DONE;
                end else begin
                    write_req = 1'b1;
                end
            end
            COPY_RD: begin
                mem_address = src_reg;
                state_next  = (remaining_reg == '0) ? DONE : COPY_WR;
            end
            COPY_WR: begin
                mem_address    = dst_reg;
                mem_write_data = hold_reg;
                write_req      = 1'b1;
                state_next     = COPY_RD;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
            hold_reg      <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        src_reg       <= ea;
                        dst_reg       <= (req_op == OP_COPY) ? req_data[ADDR_W-1:0] : ea;
                        remaining_reg <= req_len;
                        data_reg      <= req_data;
                        // Block ops report their word count; set now, held through DONE.
                        if (req_op[1]) begin
                            resp_data_reg <= {{(DATA_W-ADDR_W){1'b0}}, req_len};
                        end
                    end
                end
                LOAD:  resp_data_reg <= mem_read_data;
                STORE: resp_data_reg <= data_reg;
                FILL: begin
                    if (remaining_reg != '0) begin
                        dst_reg       <= dst_reg + ADDR_W'(1);
                        remaining_reg <= remaining_reg - ADDR_W'(1);
                    end
                end
                COPY_RD: begin
                    if (remaining_reg != '0) begin
                        hold_reg <= mem_read_data;
                    end
                end
                COPY_WR: begin
                    src_reg       <= src_reg + ADDR_W'(1);
                    dst_reg       <= dst_reg + ADDR_W'(1);
                    remaining_reg <= remaining_reg - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
